// File: rtl/instr_fetch_pkg.sv
// Shared fetch definitions: Branch codes (also used by the decoder), default NOP and FSM states.
package instr_fetch_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_EQ   = 3'b100;
    localparam logic [2:0] BR_NE   = 3'b101;
    localparam logic [2:0] BR_LT   = 3'b110;
    localparam logic [2:0] BR_GE   = 3'b111;

    // addi x0,x0,0
    localparam logic [31:0] DEFAULT_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_next_pc_sel.sv
// Redirect decision: resolves the EX Branch code and flags into take/target.
module next_pc_sel
    import instr_fetch_pkg::*;
(
    input  logic        ex_valid,
    input  logic [2:0]  ex_branch,
    input  logic        ex_zero,
    input  logic        ex_less,
    input  logic [31:0] ex_br_target,
    input  logic [31:0] ex_jr_target,
    output logic        take,
    output logic [31:0] target
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (ex_branch)
            BR_NONE: cond = 1'b0;
            BR_JAL:  cond = 1'b1;
            BR_JALR: cond = 1'b1;
            BR_EQ:   cond = ex_zero;
            BR_NE:   cond = ~ex_zero;
            BR_LT:   cond = ex_less;
            BR_GE:   cond = ~ex_less;
            default: cond = 1'b0;
        endcase
        take   = ex_valid & cond;
        target = (ex_branch == BR_JALR) ? (ex_jr_target & ~32'd1) : ex_br_target;
    end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: PC, imem req/ack fetch, IF/ID register, one-entry hold buffer, branch redirect.
// Optional FETCH_PERF_CNT_EN adds perf_fetch / perf_flush counters.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [2:0]  ex_branch,
    input  logic        ex_zero,
    input  logic        ex_less,
    input  logic [31:0] ex_br_target,
    input  logic [31:0] ex_jr_target,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_instr,
    output logic [6:0]  if_opcode,
    output logic [2:0]  if_func3,
    output logic [6:0]  if_func7
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_flush
`endif
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, drop_addr, hold_instr, hold_pc, target, addr_sel;
    logic         hold_valid, take, got_word, fetch_load, hold_load;

    next_pc_sel u_next_pc_sel (
        .ex_valid     (ex_valid),
        .ex_branch    (ex_branch),
        .ex_zero      (ex_zero),
        .ex_less      (ex_less),
        .ex_br_target (ex_br_target),
        .ex_jr_target (ex_jr_target),
        .take         (take),
        .target       (target)
    );

    assign got_word   = (state == S_REQ) && imem_ack && !take;
    assign fetch_load = got_word && !stall;
    assign hold_load  = (state == S_HOLD) && !take && !stall;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (take) begin
            // An unacked request must still be retired, so its data is swallowed in S_DROP.
            if ((state == S_REQ || state == S_DROP) && !imem_ack) state_nxt = S_DROP;
            else                                                  state_nxt = S_REQ;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_REQ;
                S_REQ:   if (imem_ack && stall) state_nxt = S_HOLD;
                S_HOLD:  if (!stall) state_nxt = S_REQ;
                S_DROP:  if (imem_ack) state_nxt = S_REQ;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req  = (state == S_REQ) || (state == S_DROP);
        addr_sel  = (state == S_DROP) ? drop_addr : pc;
        imem_addr = addr_sel & ~32'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= PC_RESET;
            drop_addr  <= '0;
            hold_valid <= 1'b0;
            hold_instr <= '0;
            hold_pc    <= '0;
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_instr   <= NOP_INSTR;
        end else if (take) begin
            pc         <= target;
            hold_valid <= 1'b0;
            if_valid   <= 1'b0;
            if_instr   <= NOP_INSTR;
            if (state == S_REQ) drop_addr <= pc;
        end else begin
            if (got_word) pc <= pc + 32'd4;
            if (got_word && stall) begin
                hold_valid <= 1'b1;
                hold_instr <= imem_rdata;
                hold_pc    <= pc;
            end
            if (fetch_load) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_instr <= imem_rdata;
            end else if (hold_load) begin
                if_valid   <= hold_valid;
                if_pc      <= hold_pc;
                if_instr   <= hold_valid ? hold_instr : NOP_INSTR;
                hold_valid <= 1'b0;
            end else if (!stall) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch <= '0;
            perf_flush <= '0;
        end else begin
            if (fetch_load || hold_load) perf_fetch <= perf_fetch + 32'd1;
            if (take)                    perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

    assign if_pc4    = if_pc + 32'd4;
    assign if_opcode = if_instr[6:0];
    assign if_func3  = if_instr[14:12];
    assign if_func7  = if_instr[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; imem returns the request address as data.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_ack, stall, ex_valid, ex_zero, ex_less, if_valid;
    logic [31:0] imem_addr, imem_rdata, ex_br_target, ex_jr_target, if_pc, if_pc4, if_instr;
    logic [2:0]  ex_branch, if_func3;
    logic [6:0]  if_opcode, if_func7;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_flush;
`endif
    int checks = 0;
    int failures = 0;
    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;
    assign imem_rdata = imem_addr;

    instr_fetch #(.PC_RESET(32'h0000_3000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .stall(stall), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_zero(ex_zero), .ex_less(ex_less), .ex_br_target(ex_br_target),
        .ex_jr_target(ex_jr_target), .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4),
        .if_instr(if_instr), .if_opcode(if_opcode), .if_func3(if_func3), .if_func7(if_func7)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch(perf_fetch), .perf_flush(perf_flush)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_branch = 3'b000;
        ex_zero = 1'b0; ex_less = 1'b0; ex_br_target = '0; ex_jr_target = '0;
        tick(); tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", if_pc); end
        checks++; if (if_instr !== NOP) begin failures++; $display("FAIL rst_instr got=%h exp=%h", if_instr, NOP); end
        checks++; if (imem_addr !== 32'h3000) begin failures++; $display("FAIL rst_addr got=%h exp=3000", imem_addr); end
        rst = 1'b0;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req got=%b exp=0", imem_req); end
    endtask

    task automatic test_sequential();
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin failures++; $display("FAIL first_req got=%b/%h exp=1/3000", imem_req, imem_addr); end
        imem_ack = 1'b1;
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3000 || if_instr !== 32'h3000) begin failures++; $display("FAIL seq0 got=%b/%h/%h exp=1/3000/3000", if_valid, if_pc, if_instr); end
        checks++; if (if_pc4 !== 32'h3004 || if_func3 !== 3'd3 || if_opcode !== 7'd0 || if_func7 !== 7'd0) begin failures++; $display("FAIL seq0_fields got=%h/%h/%h/%h exp=3004/3/0/0", if_pc4, if_func3, if_opcode, if_func7); end
        tick();
        checks++; if (if_pc !== 32'h3004 || if_instr !== 32'h3004) begin failures++; $display("FAIL seq1 got=%h/%h exp=3004/3004", if_pc, if_instr); end
        tick();
        checks++; if (if_pc !== 32'h3008 || imem_addr !== 32'h300C) begin failures++; $display("FAIL seq2 got=%h/%h exp=3008/300c", if_pc, imem_addr); end
    endtask

    task automatic test_stall_hold();
        stall = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0 || if_pc !== 32'h3008 || if_valid !== 1'b1) begin failures++; $display("FAIL hold0 got=%b/%h/%b exp=0/3008/1", imem_req, if_pc, if_valid); end
        imem_ack = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0 || if_pc !== 32'h3008) begin failures++; $display("FAIL hold1 got=%b/%h exp=0/3008", imem_req, if_pc); end
        tick();
        checks++; if (imem_req !== 1'b0 || if_instr !== 32'h3008) begin failures++; $display("FAIL hold2 got=%b/%h exp=0/3008", imem_req, if_instr); end
        stall = 1'b0;
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300C || if_instr !== 32'h300C) begin failures++; $display("FAIL hold_release got=%b/%h/%h exp=1/300c/300c", if_valid, if_pc, if_instr); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3010) begin failures++; $display("FAIL hold_nextreq got=%b/%h exp=1/3010", imem_req, imem_addr); end
        imem_ack = 1'b1;
        tick();
        checks++; if (if_pc !== 32'h3010) begin failures++; $display("FAIL hold_after got=%h exp=3010", if_pc); end
    endtask

    task automatic test_branch();
        ex_valid = 1'b1; ex_branch = 3'b100; ex_zero = 1'b1; ex_br_target = 32'h3100;
        tick();
        checks++; if (if_valid !== 1'b0 || if_instr !== NOP || imem_addr !== 32'h3100 || imem_req !== 1'b1) begin failures++; $display("FAIL beq_taken got=%b/%h/%h exp=0/%h/3100", if_valid, if_instr, imem_addr, NOP); end
        ex_zero = 1'b0; ex_br_target = 32'h3500;
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3100 || imem_addr !== 32'h3104) begin failures++; $display("FAIL beq_not got=%b/%h/%h exp=1/3100/3104", if_valid, if_pc, imem_addr); end
        ex_branch = 3'b110; ex_less = 1'b1; ex_br_target = 32'h3400;
        tick();
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h3400) begin failures++; $display("FAIL blt_taken got=%b/%h exp=0/3400", if_valid, imem_addr); end
        ex_valid = 1'b0; ex_less = 1'b0;
    endtask

    task automatic test_jalr_drop();
        imem_ack = 1'b0; ex_valid = 1'b1; ex_branch = 3'b010; ex_jr_target = 32'h3201;
        tick();
        ex_valid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3400 || if_valid !== 1'b0) begin failures++; $display("FAIL drop0 got=%b/%h/%b exp=1/3400/0", imem_req, imem_addr, if_valid); end
        tick();
        checks++; if (imem_addr !== 32'h3400) begin failures++; $display("FAIL drop1 got=%h exp=3400", imem_addr); end
        imem_ack = 1'b1;
        tick();
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h3200 || imem_req !== 1'b1) begin failures++; $display("FAIL drop_done got=%b/%h/%b exp=0/3200/1", if_valid, imem_addr, imem_req); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3200 || if_instr !== 32'h3200) begin failures++; $display("FAIL jalr_fetch got=%b/%h/%h exp=1/3200/3200", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_redirect_priority();
        imem_ack = 1'b0; stall = 1'b1; ex_valid = 1'b1; ex_branch = 3'b001; ex_br_target = 32'h3300;
        tick();
        checks++; if (if_valid !== 1'b0 || if_instr !== NOP || imem_addr !== 32'h3204) begin failures++; $display("FAIL take_stall got=%b/%h/%h exp=0/%h/3204", if_valid, if_instr, imem_addr, NOP); end
        ex_valid = 1'b0; stall = 1'b0; imem_ack = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'h3300 || if_valid !== 1'b0) begin failures++; $display("FAIL take_stall_req got=%h/%b exp=3300/0", imem_addr, if_valid); end
        tick();
        checks++; if (if_pc !== 32'h3300 || if_valid !== 1'b1) begin failures++; $display("FAIL take_stall_fetch got=%h/%b exp=3300/1", if_pc, if_valid); end
        stall = 1'b1; ex_valid = 1'b1; ex_branch = 3'b101; ex_zero = 1'b0; ex_br_target = 32'h3600;
        tick();
        checks++; if (if_valid !== 1'b0 || if_instr !== NOP || imem_addr !== 32'h3600 || imem_req !== 1'b1) begin failures++; $display("FAIL take_ack got=%b/%h/%h/%b exp=0/%h/3600/1", if_valid, if_instr, imem_addr, imem_req, NOP); end
        ex_valid = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset_and_wrap();
        imem_ack = 1'b0;
        tick();
        rst = 1'b1; imem_ack = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== NOP || imem_addr !== 32'h3000) begin failures++; $display("FAIL mid_rst got=%b/%b/%h/%h/%h exp=0/0/0/%h/3000", imem_req, if_valid, if_pc, if_instr, imem_addr, NOP); end
        rst = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || if_valid !== 1'b0) begin failures++; $display("FAIL late_ack got=%b/%h/%b exp=1/3000/0", imem_req, imem_addr, if_valid); end
        ex_valid = 1'b1; ex_branch = 3'b001; ex_br_target = 32'hFFFF_FFFC;
        tick();
        ex_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req got=%h exp=fffffffc", imem_addr); end
        tick();
        checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'h0 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap got=%h/%h/%h exp=fffffffc/0/0", if_pc, if_pc4, imem_addr); end
        tick();
        checks++; if (if_pc !== 32'h0 || if_valid !== 1'b1 || if_instr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%h/%b/%h exp=0/1/0", if_pc, if_valid, if_instr); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_fetch !== 32'd2 || perf_flush !== 32'd1) begin failures++; $display("FAIL perf got=%0d/%0d exp=2/1", perf_fetch, perf_flush); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_branch();
        test_jalr_drop();
        test_redirect_priority();
        test_reset_and_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
